sqrt_lut_arbiter: RTL
=====================

# sqrt_lut_arbiter

Round-robin scheduler that shares one fixed-latency `sqrt_lut` instance between `NUM_REQ` requesters. Each requester gets its own valid/ready request and response channels, and results are routed back by tag. Per-requester credit counters and response FIFOs absorb backpressure, because `sqrt_lut` cannot stall. The block sits between the pixel/magnitude producers and the single `sqrt_lut` instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `LAT`, 3: `sqrt_lut` latency, `lut_val_o` cycle minus `lut_val_i` cycle.
- `DEPTH`, 4: per-requester response FIFO depth. This is also the credit limit.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ: request valid, one bit per requester.
- `req_data`  in  16*NUM_REQ: radicand; requester i uses bits [16i+15:16i].
- `req_ready`  out  NUM_REQ: accept strobe. A request transfers when valid & ready.
- `rsp_valid`  out  NUM_REQ: response available (head of FIFO i).
- `rsp_data`  out  8*NUM_REQ: root; requester i uses bits [8i+7:8i].
- `rsp_ready`  in  NUM_REQ: response consumed when valid & ready.
- `lut_i`  out  16: to `sqrt_lut_i`.
- `lut_val_i`  out  1: to `sqrt_lut` `val_i`.
- `lut_o`  in  8: from `sqrt_lut_o`.
- `lut_val_o`  in  1: from `sqrt_lut` `val_o`.
- `err`  out  1: sticky. Set when `lut_val_o` arrives with no matching tag.

## Operation
- **Credits.** `cnt[i]` counts requester i's in-flight requests plus its FIFO occupancy (0..DEPTH).
  - Requester i is eligible when `req_valid[i]` is high and `cnt[i] < DEPTH`.
- **Arbitration.** One grant per cycle at most.
  - The search starts at `ptr+1` modulo NUM_REQ; the first eligible requester wins.
  - `req_ready` is one-hot equal to the grant; it may depend combinationally on `req_valid`.
  - `ptr` updates to the granted index only when a grant occurs.
- **Issue.** On grant, the next cycle drives `lut_val_i=1` and `lut_i` = the granted `req_data`.
  - The same cycle pushes {valid=1, tag=index} into a LAT-stage tag shift register.
  - With no grant, `lut_val_i=0`, `lut_i` holds its last value, and a {valid=0} entry is pushed.
- **Return.**
  - When `lut_val_o` and the tag-pipe output valid are both high, `lut_o` is written into FIFO[tag].
  - When `lut_val_o` is high and the tag valid is low, the result is dropped and `err` is set.
  - When the tag valid is high and `lut_val_o` is low, `err` is also set and the credit is released.
- **Response.** Each FIFO is show-ahead: `rsp_data` is the head entry and `rsp_valid` means not empty.
  - A pop happens on `rsp_valid & rsp_ready`.
- **Counter update.**
  - `cnt[i]` increments on grant and decrements on pop (or on a released credit).
  - When both happen in the same cycle, `cnt[i]` is unchanged.
  - It never exceeds DEPTH and never underflows.
- **FIFO safety.** A FIFO cannot overflow, because a write is only possible for a credited request.

## Timing
- **Reset values.**
  - `req_ready=0`, `rsp_valid=0`, `lut_val_i=0`, `lut_i=0`, `err=0`.
  - All `cnt=0`, FIFOs empty, tag pipe valid bits cleared.
  - `ptr=NUM_REQ-1`, so requester 0 is searched first.
- **Latency.** Accept in cycle N gives `lut_val_i` at N+1, `lut_val_o` at N+1+LAT, and FIFO write at that edge. `rsp_valid` is high at N+2+LAT (N+5 with LAT=3).
- **Throughput.** One request per cycle aggregate. Per requester it is limited by DEPTH credits when `rsp_ready` is low.
- **Fairness.** With all requesters continuously eligible, grants rotate 0,1,..,NUM_REQ-1 with no repeats.
- **Reset mid-operation.**
  - `sqrt_lut` is not reset, so stale `lut_val_o` pulses may arrive within LAT+1 cycles after `rst` falls.
  - The cleared tag valid bits drop these results, and the drop sets `err`. The bench masks `err` for LAT+1 cycles after reset.
  - `rst` has priority over every simultaneous event.
- **Same-cycle events.** Push and pop on the same FIFO in one cycle are both performed. A FIFO that is full while a pop occurs can accept a write in the same cycle.

## Test plan
- **Single request.** After reset, requester 0 sends 16'd1024 (bench `sqrt_lut` model: floor sqrt, LAT=3). Required: `req_ready[0]` high the same cycle, `lut_val_i` one cycle later, and `rsp_valid[0]` with `rsp_data`=8'd32 exactly 5 cycles after acceptance.
- **Round robin.** All 4 requesters hold `req_valid`, with data 16'd4, 16'd9, 16'd16, 16'd25. Required: grants 0,1,2,3,0,... on consecutive cycles, and responses 2,3,4,5 each routed to its own requester.
- **Credit stall.** Requester 2 streams with `rsp_ready[2]=0`. Required: exactly 4 accepts, then `req_ready[2]` stays low while other requesters are still granted. Raising `rsp_ready[2]` for one cycle re-enables one more accept.
- **Same-cycle accept and pop.** Requester 1 is at `cnt`=4 and pops in the same cycle another grant would become possible. Required: `cnt` goes 4→3→4 correctly, and no FIFO overflow or lost entry.
- **Reset mid-flight.** Assert `rst` for 1 cycle while 3 requests are in flight. Required: no `rsp_valid` from stale results, `err` set by the stale pulses (masked), and normal operation resumes with the requester 0 grant first.
- **Spurious return.** Force `lut_val_o=1` with the tag pipe empty. Required: `err` goes to 1 and stays sticky until `rst`, and no FIFO is written.

Source files
------------

// File: rtl/sqrt_lut_arbiter.sv
// sqrt_lut_arbiter: round-robin sharing of one fixed-latency sqrt_lut between
// NUM_REQ requesters. Results return by tag into per-requester show-ahead FIFOs.
// Credit counters bound in-flight plus queued results to DEPTH for each requester.
module sqrt_lut_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 3,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [8*NUM_REQ-1:0]    rsp_data,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [15:0]             lut_i,
    output logic                    lut_val_i,
    input  logic [7:0]              lut_o,
    input  logic                    lut_val_o,
    output logic                    err
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_I  = IW'(NUM_REQ - 1);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q [NUM_REQ];
    logic [CW-1:0] cnt_d [NUM_REQ];
    logic [CW-1:0] occ_q [NUM_REQ];
    logic [CW-1:0] occ_d [NUM_REQ];
    logic [AW-1:0] rd_q  [NUM_REQ];
    logic [AW-1:0] rd_d  [NUM_REQ];
    logic [AW-1:0] wr_q  [NUM_REQ];
    logic [AW-1:0] wr_d  [NUM_REQ];
    logic [7:0]    mem_q [NUM_REQ][DEPTH];
    logic [7:0]    mem_d [NUM_REQ][DEPTH];
    logic [15:0]   lut_i_q, lut_i_d;
    logic          lut_val_i_q, lut_val_i_d;
    logic [IW-1:0] iss_tag_q, iss_tag_d;
    logic [LAT-1:0] tv_q, tv_d;
    logic [IW-1:0] tt_q [LAT];
    logic [IW-1:0] tt_d [LAT];
    logic          err_q, err_d;

    logic [NUM_REQ-1:0] grant, pop, push, rel;
    logic               grant_any;
    logic [IW-1:0]      grant_idx;
    logic               tag_v;
    logic [IW-1:0]      tag;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int unsigned idx;
        logic [IW-1:0] cand;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = ptr_q;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx  = (32'(ptr_q) + off) % NUM_REQ;
            cand = IW'(idx);
            if (!grant_any && !rst && req_valid[cand] && (cnt_q[cand] < DEPTH_C)) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Tag-pipe output steers a returning result into its FIFO or releases its credit.
    always_comb begin
        tag_v = tv_q[LAT-1];
        tag   = tt_q[LAT-1];
        push  = '0;
        rel   = '0;
        if (tag_v && lut_val_o) begin
            push[tag] = 1'b1;
        end
        if (tag_v && !lut_val_o) begin
            rel[tag] = 1'b1;
        end
    end

    // Show-ahead FIFO heads and handshake outputs.
    always_comb begin
        rsp_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i]        = (occ_q[i] != '0);
            rsp_data[8*i +: 8]  = mem_q[i][rd_q[i]];
        end
        pop       = rsp_valid & rsp_ready;
        req_ready = grant;
        lut_i     = lut_i_q;
        lut_val_i = lut_val_i_q;
        err       = err_q;
    end

    // Next state for issue register, tag pipe, credits and FIFOs.
    always_comb begin
        ptr_d       = grant_any ? grant_idx : ptr_q;
        lut_val_i_d = grant_any;
        iss_tag_d   = grant_any ? grant_idx : iss_tag_q;
        lut_i_d     = lut_i_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                lut_i_d = req_data[16*i +: 16];
            end
        end
        tv_d[0] = lut_val_i_q;
        tt_d[0] = iss_tag_q;
        for (int unsigned k = 1; k < LAT; k++) begin
            tv_d[k] = tv_q[k-1];
            tt_d[k] = tt_q[k-1];
        end
        err_d = err_q | (lut_val_o ^ tag_v);
        mem_d = mem_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i] + CW'(grant[i]) - CW'(pop[i]) - CW'(rel[i]);
            occ_d[i] = occ_q[i] + CW'(push[i]) - CW'(pop[i]);
            wr_d[i]  = wr_q[i];
            rd_d[i]  = rd_q[i];
            if (push[i]) begin
                mem_d[i][wr_q[i]] = lut_o;
                wr_d[i] = (wr_q[i] == LAST_A) ? '0 : wr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rd_d[i] = (rd_q[i] == LAST_A) ? '0 : rd_q[i] + 1'b1;
            end
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= LAST_I;
            lut_i_q     <= '0;
            lut_val_i_q <= 1'b0;
            iss_tag_q   <= '0;
            tv_q        <= '0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
                occ_q[i] <= '0;
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            lut_i_q     <= lut_i_d;
            lut_val_i_q <= lut_val_i_d;
            iss_tag_q   <= iss_tag_d;
            tv_q        <= tv_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            occ_q       <= occ_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
        end
    end

    // Data storage and tag indexes; qualified by valid/occupancy, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        tt_q  <= tt_d;
    end

endmodule
